aes_word_fifo: RTL and testbench

AES_WORD_FIFO -- requirements
Module: aes_word_fifo

---
 rtl/aes_pkg.sv | 7 +
 rtl/aes_word_fifo.sv | 78 +++++++
 tb/tb_aes_word_fifo.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES word/block sizing constants
package aes_pkg;

  localparam int AES_WORD_W      = 32;
  localparam int AES_BLOCK_WORDS = 4;

endpackage

// File: rtl/aes_word_fifo.sv
// rtl/aes_word_fifo.sv - fall-through word FIFO with occupancy, almost-full and sticky overflow flag
module aes_word_fifo
  import aes_pkg::*;
#(
  parameter int DATA_W    = AES_WORD_W,
  parameter int DEPTH     = AES_BLOCK_WORDS,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  // Status depends only on the count register, so in_ready never sees out_ready.
  assign in_ready    = (count != FULL_CNT);
  assign out_valid   = (count != '0);
  assign almost_full = (count >= AFULL_CNT);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_data    = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (in_valid && !in_ready) begin
        ovf_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_word_fifo.sv
// tb/tb_aes_word_fifo.sv - scoreboard bench for aes_word_fifo with directed and random traffic
module tb_aes_word_fifo;

  localparam int DEPTH = 4;
  localparam int AFULL = DEPTH - 1;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [2:0]  count;
  logic        almost_full;
  logic        ovf_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  int          mcount = 0;
  logic        movf   = 1'b0;
  logic        mon_en = 1'b0;

  aes_word_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .count      (count),
    .almost_full(almost_full),
    .ovf_err    (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle, compare status with the model and pop the scoreboard on each transfer.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      chk("mon_count", 32'(count), 32'(mcount));
      chk("mon_in_ready", 32'(in_ready), 32'(mcount != DEPTH));
      chk("mon_out_valid", 32'(out_valid), 32'(mcount != 0));
      chk("mon_almost_full", 32'(almost_full), 32'(mcount >= AFULL));
      chk("mon_ovf_err", 32'(ovf_err), 32'(movf));
      if (!out_valid) begin
        chk("mon_empty_data", out_data, 32'h0);
      end else if (out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          chk("mon_scoreboard_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("mon_out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  // Apply one cycle of inputs (called at posedge+1), then update the model for that edge.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    logic acc;
    logic rd;
    int   old;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    old = mcount;
    acc = iv && (mcount < DEPTH) && !fl;
    rd  = ordy && (mcount > 0) && !fl;
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
    if (fl) begin
      mcount = 0;
      movf   = 1'b0;
    end else begin
      mcount = mcount + int'(acc) - int'(rd);
      if (iv && old == DEPTH) movf = 1'b1;
    end
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    chk("rst_ovf_err", 32'(ovf_err), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Three pushes with consumer stalled
    cycle(1'b1, 32'h11111111, 1'b0, 1'b0);
    chk("fallthrough_data", out_data, 32'h11111111);
    chk("fallthrough_valid", 32'(out_valid), 32'd1);
    cycle(1'b1, 32'h22222222, 1'b0, 1'b0);
    cycle(1'b1, 32'h33333333, 1'b0, 1'b0);
    chk("p3_count", 32'(count), 32'd3);
    chk("p3_almost_full", 32'(almost_full), 32'd1);
    chk("p3_head", out_data, 32'h11111111);

    // Fill, then push into a full FIFO
    cycle(1'b1, 32'h44444444, 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ovf_before", 32'(ovf_err), 32'd0);
    cycle(1'b1, 32'h55555555, 1'b0, 1'b0);
    chk("ovf_set", 32'(ovf_err), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    idle();
    idle();
    chk("ovf_sticky", 32'(ovf_err), 32'd1);

    // Full with push and pop together: only the pop happens
    cycle(1'b1, 32'h66666666, 1'b1, 1'b0);
    chk("fullpp_count", 32'(count), 32'd3);
    chk("fullpp_in_ready", 32'(in_ready), 32'd1);
    chk("fullpp_head", out_data, 32'h22222222);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("flush_ovf_clear", 32'(ovf_err), 32'd0);
    chk("flush_count", 32'(count), 32'd0);

    // Streaming: count holds at 1 while pointers lap several times
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 32'(i), 1'b1, 1'b0);
      chk("stream_count", 32'(count), 32'd1);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stream_drained", 32'(count), 32'd0);

    // Flush at count=2 with concurrent push and pop
    cycle(1'b1, 32'hA0A0A0A0, 1'b0, 1'b0);
    cycle(1'b1, 32'hB1B1B1B1, 1'b0, 1'b0);
    cycle(1'b1, 32'hC2C2C2C2, 1'b1, 1'b1);
    chk("flush2_count", 32'(count), 32'd0);
    chk("flush2_out_valid", 32'(out_valid), 32'd0);
    chk("flush2_out_data", out_data, 32'h0);
    chk("flush2_ovf", 32'(ovf_err), 32'd0);

    // Reset between edges at count=3
    cycle(1'b1, 32'hD0000001, 1'b0, 1'b0);
    cycle(1'b1, 32'hD0000002, 1'b1, 1'b0);
    cycle(1'b1, 32'hD0000003, 1'b0, 1'b0);
    cycle(1'b1, 32'hD0000004, 1'b0, 1'b0);
    chk("prerst_count", 32'(count), 32'd3);
    in_valid = 1'b0;
    #2;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_data", out_data, 32'h0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    mcount = 0;
    movf   = 1'b0;
    mon_en = 1'b1;
    cycle(1'b1, 32'hE0E0E0E0, 1'b0, 1'b0);
    chk("postrst_head", out_data, 32'hE0E0E0E0);
    cycle(1'b1, 32'hE1E1E1E1, 1'b1, 1'b0);
    chk("postrst_second", out_data, 32'hE1E1E1E1);

    // Random traffic checked by the scoreboard monitor
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), $urandom(),
            1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 2));
    end

    for (int i = 0; i < DEPTH + 2; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("final_count", 32'(count), 32'd0);
    chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
